ysyx_bus_rr_arbiter: RTL and testbench

Shares the single AXI4 master port between the IFU read requester and the LSU read/write requester, with one outstanding transaction at a time. Writes take priority over reads; competing IFU and LSU reads alternate round-robin. Requester addresses are latched on acceptance. Beats are lane-steered between the 32-bit requester side and the 64-bit bus. The block sits between the core's fetch/load-store units and the SoC AXI4 master port.

---
 rtl/ysyx_bus_rr_arbiter.sv | 152 +++++++++++++++
 tb/tb_ysyx_bus_rr_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_bus_rr_arbiter.sv
// ysyx_bus_rr_arbiter: shares one AXI4 master between IFU reads and LSU reads/writes; one transaction at a time, writes first, reads round-robin; ports: requester ifu_*/lsu_* handshakes, io_master_* AXI4 master
module ysyx_bus_rr_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_arvalid,
  input  logic [ADDR_W-1:0] ifu_araddr,
  output logic              ifu_arready_o,
  output logic              ifu_rvalid_o,
  output logic [DATA_W-1:0] ifu_rdata_o,
  output logic              ifu_rerr_o,
  input  logic              lsu_arvalid,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [2:0]        lsu_arsize,
  output logic              lsu_arready_o,
  output logic              lsu_rvalid_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              lsu_rerr_o,
  input  logic              lsu_awvalid,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic [2:0]        lsu_awsize,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [3:0]        lsu_wstrb,
  output logic              lsu_awready_o,
  output logic              lsu_bvalid_o,
  output logic              lsu_berr_o,
  output logic              io_master_arvalid,
  input  logic              io_master_arready,
  output logic [ADDR_W-1:0] io_master_araddr,
  output logic [2:0]        io_master_arsize,
  output logic [7:0]        io_master_arlen,
  output logic [1:0]        io_master_arburst,
  output logic [3:0]        io_master_arid,
  input  logic              io_master_rvalid,
  output logic              io_master_rready,
  input  logic [63:0]       io_master_rdata,
  input  logic [1:0]        io_master_rresp,
  input  logic              io_master_rlast,
  input  logic [3:0]        io_master_rid,
  output logic              io_master_awvalid,
  input  logic              io_master_awready,
  output logic [ADDR_W-1:0] io_master_awaddr,
  output logic [2:0]        io_master_awsize,
  output logic [7:0]        io_master_awlen,
  output logic [1:0]        io_master_awburst,
  output logic [3:0]        io_master_awid,
  output logic              io_master_wvalid,
  input  logic              io_master_wready,
  output logic [63:0]       io_master_wdata,
  output logic [7:0]        io_master_wstrb,
  output logic              io_master_wlast,
  input  logic              io_master_bvalid,
  output logic              io_master_bready,
  input  logic [1:0]        io_master_bresp,
  input  logic [3:0]        io_master_bid
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_B} state_t;
  state_t            state;
  logic              owner_lsu, last_lsu, aw_done, w_done;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic              idle, gnt_w, gnt_l, gnt_i, r_fire, b_fire, aw_n, w_n;
  logic [31:0]       r_lane;
  logic              unused;
  assign unused = ^{io_master_rlast, io_master_rid, io_master_bid};
  // a grant is never offered while reset is pending, so nothing is accepted and then lost
  assign idle  = state == IDLE && !rst;
  assign gnt_w = idle && lsu_awvalid;
  // on a read tie, last_lsu picks whichever requester was not served last
  assign gnt_l = idle && !lsu_awvalid && lsu_arvalid && (!ifu_arvalid || !last_lsu);
  assign gnt_i = idle && !lsu_awvalid && ifu_arvalid && (!lsu_arvalid || last_lsu);
  assign r_fire = state == RD_D && io_master_rvalid;
  assign b_fire = state == WR_B && io_master_bvalid;
  assign aw_n   = aw_done || io_master_awready;
  assign w_n    = w_done || io_master_wready;
  assign r_lane = addr_q[2] ? io_master_rdata[63:32] : io_master_rdata[31:0];
  assign ifu_arready_o = gnt_i;
  assign lsu_arready_o = gnt_l;
  assign lsu_awready_o = gnt_w;
  assign ifu_rvalid_o  = r_fire && !owner_lsu;
  assign lsu_rvalid_o  = r_fire && owner_lsu;
  assign ifu_rdata_o   = ifu_rvalid_o ? r_lane : '0;
  assign lsu_rdata_o   = lsu_rvalid_o ? r_lane : '0;
  assign ifu_rerr_o    = ifu_rvalid_o && io_master_rresp != 2'd0;
  assign lsu_rerr_o    = lsu_rvalid_o && io_master_rresp != 2'd0;
  assign lsu_bvalid_o  = b_fire;
  assign lsu_berr_o    = b_fire && io_master_bresp != 2'd0;
  assign io_master_arvalid = state == RD_A;
  assign io_master_araddr  = addr_q;
  assign io_master_arsize  = size_q;
  assign io_master_arlen   = 8'd0;
  assign io_master_arburst = 2'b01;
  assign io_master_arid    = 4'd0;
  assign io_master_rready  = state == RD_D;
  assign io_master_awvalid = state == WR_A && !aw_done;
  assign io_master_awaddr  = addr_q;
  assign io_master_awsize  = size_q;
  assign io_master_awlen   = 8'd0;
  assign io_master_awburst = 2'b01;
  assign io_master_awid    = 4'd0;
  assign io_master_wvalid  = state == WR_A && !w_done;
  assign io_master_wdata   = {wdata_q, wdata_q};
  assign io_master_wstrb   = addr_q[2] ? {wstrb_q, 4'b0} : {4'b0, wstrb_q};
  assign io_master_wlast   = 1'b1;
  assign io_master_bready  = state == WR_B;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner_lsu <= 1'b0;
      last_lsu  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_w) begin
            addr_q  <= lsu_awaddr;
            size_q  <= lsu_awsize;
            wdata_q <= lsu_wdata;
            wstrb_q <= lsu_wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WR_A;
          end else if (gnt_l || gnt_i) begin
            addr_q    <= gnt_l ? lsu_araddr : ifu_araddr;
            size_q    <= gnt_l ? lsu_arsize : 3'd2;
            owner_lsu <= gnt_l;
            last_lsu  <= gnt_l;
            state     <= RD_A;
          end
        end
        RD_A: state <= io_master_arready ? RD_D : RD_A;
        RD_D: state <= io_master_rvalid ? IDLE : RD_D;
        WR_A: begin
          aw_done <= aw_n && !w_n;
          w_done  <= w_n && !aw_n;
          state   <= aw_n && w_n ? WR_B : WR_A;
        end
        WR_B: state <= io_master_bvalid ? IDLE : WR_B;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_bus_rr_arbiter.sv
// tb_ysyx_bus_rr_arbiter: table-driven and sequence checks of the bus arbiter with a response scoreboard
module tb_ysyx_bus_rr_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic ifu_arvalid = 0, lsu_arvalid = 0, lsu_awvalid = 0;
  logic [31:0] ifu_araddr = 0, lsu_araddr = 0, lsu_awaddr = 0, lsu_wdata = 0;
  logic [2:0] lsu_arsize = 0, lsu_awsize = 0;
  logic [3:0] lsu_wstrb = 0;
  logic ifu_arready_o, ifu_rvalid_o, ifu_rerr_o, lsu_arready_o, lsu_rvalid_o, lsu_rerr_o;
  logic lsu_awready_o, lsu_bvalid_o, lsu_berr_o;
  logic [31:0] ifu_rdata_o, lsu_rdata_o;
  logic m_arvalid, m_arready = 0, m_rvalid = 0, m_rready, m_rlast = 1;
  logic m_awvalid, m_awready = 0, m_wvalid, m_wready = 0, m_wlast, m_bvalid = 0, m_bready;
  logic [31:0] m_araddr, m_awaddr;
  logic [2:0] m_arsize, m_awsize;
  logic [7:0] m_arlen, m_awlen, m_wstrb;
  logic [1:0] m_arburst, m_awburst, m_rresp = 0, m_bresp = 0;
  logic [3:0] m_arid, m_awid, m_rid = 0, m_bid = 0;
  logic [63:0] m_rdata = 0, m_wdata;
  int cyc = 0, total = 0, passes = 0;
  typedef struct {logic lsu; logic [31:0] addr; logic [2:0] size; logic [63:0] rdata; logic [1:0] resp; logic [2:0] exp_size; logic [31:0] exp_data; logic exp_err;} vec_t;
  typedef struct {int kind; logic [31:0] data; logic err; int cyc;} exp_t;
  vec_t v[6];
  exp_t q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ysyx_bus_rr_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready_o(ifu_arready_o),
    .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o), .ifu_rerr_o(ifu_rerr_o),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arready_o(lsu_arready_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o), .lsu_rerr_o(lsu_rerr_o),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awsize(lsu_awsize), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_awready_o(lsu_awready_o), .lsu_bvalid_o(lsu_bvalid_o), .lsu_berr_o(lsu_berr_o),
    .io_master_arvalid(m_arvalid), .io_master_arready(m_arready), .io_master_araddr(m_araddr),
    .io_master_arsize(m_arsize), .io_master_arlen(m_arlen), .io_master_arburst(m_arburst), .io_master_arid(m_arid),
    .io_master_rvalid(m_rvalid), .io_master_rready(m_rready), .io_master_rdata(m_rdata), .io_master_rresp(m_rresp),
    .io_master_rlast(m_rlast), .io_master_rid(m_rid),
    .io_master_awvalid(m_awvalid), .io_master_awready(m_awready), .io_master_awaddr(m_awaddr),
    .io_master_awsize(m_awsize), .io_master_awlen(m_awlen), .io_master_awburst(m_awburst), .io_master_awid(m_awid),
    .io_master_wvalid(m_wvalid), .io_master_wready(m_wready), .io_master_wdata(m_wdata), .io_master_wstrb(m_wstrb),
    .io_master_wlast(m_wlast), .io_master_bvalid(m_bvalid), .io_master_bready(m_bready), .io_master_bresp(m_bresp),
    .io_master_bid(m_bid)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [14:0] outs;
    return {ifu_arready_o, ifu_rvalid_o, |ifu_rdata_o, ifu_rerr_o, lsu_arready_o, lsu_rvalid_o, |lsu_rdata_o,
            lsu_rerr_o, lsu_awready_o, lsu_bvalid_o, lsu_berr_o, m_arvalid, m_rready, m_awvalid | m_wvalid, m_bready};
  endfunction
  always @(negedge clk) begin
    if (ifu_rvalid_o || lsu_rvalid_o || lsu_bvalid_o) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL spurious_resp: got ifu=%0b lsu=%0b b=%0b, expected no response", ifu_rvalid_o, lsu_rvalid_o, lsu_bvalid_o);
      end else begin
        exp_t e;
        int k;
        e = q.pop_front();
        k = lsu_bvalid_o ? 2 : lsu_rvalid_o ? 1 : 0;
        chk("resp_pulses", $countones({ifu_rvalid_o, lsu_rvalid_o, lsu_bvalid_o}), 1);
        chk("resp_kind", k, e.kind);
        chk("resp_cycle", cyc, e.cyc);
        if (k == 2) chk("berr", lsu_berr_o, e.err);
        else begin
          chk("rdata", k == 1 ? lsu_rdata_o : ifu_rdata_o, e.data);
          chk("rerr", k == 1 ? lsu_rerr_o : ifu_rerr_o, e.err);
        end
      end
    end
  end
  task automatic rd_txn(input bit lsu, input logic [31:0] addr, input logic [2:0] size, input logic [63:0] rd,
                        input logic [1:0] resp, input logic [31:0] exp_data, input bit exp_err, input bit keep);
    @(negedge clk);
    chk(lsu ? "grant_lsu" : "grant_ifu", {lsu_awready_o, lsu_arready_o, ifu_arready_o}, lsu ? 3'b010 : 3'b001);
    q.push_back('{lsu ? 1 : 0, exp_data, exp_err, cyc + 2});
    tick;
    if (!keep) begin
      if (lsu) lsu_arvalid = 0;
      else ifu_arvalid = 0;
    end
    m_arready = 1;
    @(negedge clk);
    chk("ar_chan", {m_arvalid, m_arlen, m_arburst, m_arid}, {1'b1, 8'd0, 2'b01, 4'd0});
    chk("araddr", m_araddr, addr);
    chk("arsize", m_arsize, size);
    chk("busy_no_grant", {lsu_awready_o, lsu_arready_o, ifu_arready_o}, 0);
    tick;
    m_arready = 0;
    m_rvalid = 1;
    m_rdata = rd;
    m_rresp = resp;
    @(negedge clk);
    chk("rready", m_rready, 1);
    tick;
    m_rvalid = 0;
  endtask
  initial begin
    v[0] = '{0, 32'h3000_0004, 3'd0, 64'hAAAA_BBBB_CCCC_DDDD, 2'd0, 3'd2, 32'hAAAA_BBBB, 1'b0};
    v[1] = '{0, 32'h3000_0000, 3'd0, 64'hAAAA_BBBB_CCCC_DDDD, 2'd0, 3'd2, 32'hCCCC_DDDD, 1'b0};
    v[2] = '{1, 32'h8000_0010, 3'd0, 64'h1122_3344_5566_7788, 2'd0, 3'd0, 32'h5566_7788, 1'b0};
    v[3] = '{1, 32'h8000_000C, 3'd1, 64'h1122_3344_5566_7788, 2'd0, 3'd1, 32'h1122_3344, 1'b0};
    v[4] = '{0, 32'h3000_0008, 3'd0, 64'h0123_4567_89AB_CDEF, 2'd2, 3'd2, 32'h89AB_CDEF, 1'b1};
    v[5] = '{1, 32'h8000_0004, 3'd2, 64'h0123_4567_89AB_CDEF, 2'd3, 3'd2, 32'h0123_4567, 1'b1};
    tick;
    tick;
    @(negedge clk);
    chk("reset_outs", outs(), 0);
    tick;
    rst = 0;
    @(negedge clk);
    chk("post_reset_outs", outs(), 0);
    tick;
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0010;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_0014; lsu_arsize = 3'd2;
    rd_txn(1, 32'h8000_0014, 3'd2, 64'hFEDC_BA98_7654_3210, 2'd0, 32'hFEDC_BA98, 0, 1);
    rd_txn(0, 32'h3000_0010, 3'd2, 64'hFEDC_BA98_7654_3210, 2'd0, 32'h7654_3210, 0, 1);
    rd_txn(1, 32'h8000_0014, 3'd2, 64'hFEDC_BA98_7654_3210, 2'd0, 32'hFEDC_BA98, 0, 1);
    ifu_arvalid = 0;
    lsu_arvalid = 0;
    for (int i = 0; i < 6; i++) begin
      if (v[i].lsu) begin
        lsu_arvalid = 1; lsu_araddr = v[i].addr; lsu_arsize = v[i].size;
      end else begin
        ifu_arvalid = 1; ifu_araddr = v[i].addr;
      end
      rd_txn(v[i].lsu, v[i].addr, v[i].exp_size, v[i].rdata, v[i].resp, v[i].exp_data, v[i].exp_err, 0);
    end
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_0006; lsu_awsize = 3'd1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b1100;
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0020;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_0024; lsu_arsize = 3'd2;
    @(negedge clk);
    chk("write_priority", {lsu_awready_o, lsu_arready_o, ifu_arready_o}, 3'b100);
    tick;
    lsu_awvalid = 0; m_awready = 1; m_wready = 1;
    @(negedge clk);
    chk("aw_w_valid", {m_awvalid, m_wvalid, m_wlast}, 3'b111);
    chk("wstrb_hi", m_wstrb, 8'b1100_0000);
    chk("wdata_dup", m_wdata, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("awaddr", {m_awaddr, m_awsize}, {32'h8000_0006, 3'd1});
    chk("aw_fixed", {m_awlen, m_awburst, m_awid}, {8'd0, 2'b01, 4'd0});
    tick;
    m_awready = 0; m_wready = 0; m_bvalid = 1; m_bresp = 0;
    q.push_back('{2, 32'd0, 1'b0, cyc});
    @(negedge clk);
    chk("bready", {m_bready, m_awvalid, m_wvalid}, 3'b100);
    tick;
    m_bvalid = 0;
    rd_txn(0, 32'h3000_0020, 3'd2, 64'h5555_6666_7777_8888, 2'd0, 32'h7777_8888, 0, 0);
    rd_txn(1, 32'h8000_0024, 3'd2, 64'h5555_6666_7777_8888, 2'd0, 32'h5555_6666, 0, 0);
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_0000; lsu_awsize = 3'd2; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'b0011;
    @(negedge clk);
    chk("split_grant", lsu_awready_o, 1);
    tick;
    lsu_awvalid = 0; m_awready = 1;
    @(negedge clk);
    chk("split_c1", {m_awvalid, m_wvalid}, 2'b11);
    chk("wstrb_lo", m_wstrb, 8'b0000_0011);
    tick;
    m_awready = 0;
    @(negedge clk);
    chk("split_c2", {m_awvalid, m_wvalid, m_bready}, 3'b010);
    tick;
    m_bvalid = 1; m_bresp = 3;
    @(negedge clk);
    chk("early_b_ignored", {lsu_bvalid_o, m_awvalid, m_wvalid}, 3'b001);
    tick;
    m_bvalid = 0; m_wready = 1;
    @(negedge clk);
    chk("split_c4", {m_awvalid, m_wvalid, m_bready}, 3'b010);
    tick;
    m_wready = 0;
    @(negedge clk);
    chk("split_wr_b", {m_awvalid, m_wvalid, m_bready, lsu_bvalid_o}, 4'b0010);
    tick;
    m_bvalid = 1; m_bresp = 3;
    q.push_back('{2, 32'd0, 1'b1, cyc});
    tick;
    m_bvalid = 0; m_bresp = 0;
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0000;
    @(negedge clk);
    chk("rst_txn_grant", ifu_arready_o, 1);
    tick;
    ifu_arvalid = 0; m_arready = 1;
    tick;
    m_arready = 0; rst = 1;
    @(negedge clk);
    chk("rst_in_rd_d", m_rready, 1);
    tick;
    rst = 0;
    @(negedge clk);
    chk("after_mid_reset", outs(), 0);
    tick;
    m_rvalid = 1; m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("late_r_ignored", {ifu_rvalid_o, lsu_rvalid_o, m_rready}, 0);
    tick;
    m_rvalid = 0;
    ifu_arvalid = 1; ifu_araddr = 32'h3000_0004;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_0000; lsu_arsize = 3'd2;
    rd_txn(1, 32'h8000_0000, 3'd2, 64'h9999_AAAA_BBBB_CCCC, 2'd0, 32'hBBBB_CCCC, 0, 0);
    rd_txn(0, 32'h3000_0004, 3'd2, 64'h9999_AAAA_BBBB_CCCC, 2'd0, 32'h9999_AAAA, 0, 0);
    tick;
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
